lsu_ahb_req_queue: RTL and testbench
====================================

Name: lsu_ahb_req_queue

Overview:
- Sits between the core LSU and the AHB-Lite top's `ahbm_lsu_*` request/response interface; it drives that interface.
- Buffers up to DEPTH LSU requests, issues them one at a time, and extracts plus sign/zero-extends load data from the returned bus word.
- Rejects illegal or misaligned accesses locally with an error response, in order, without touching the bus.

Parameters:
DEPTH, 4, request FIFO entries; power of two, >=2
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
lsu_req_vld  in  1  LSU request valid
lsu_req_rdy  out  1  queue can accept (= !full)
lsu_req_wen  in  1  1 = store
lsu_req_rwtyp  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_req_addr  in  AW  byte address
lsu_req_wdata  in  DW  store data, LSB-justified
lsu_rsp_vld  out  1  response valid
lsu_rsp_rdy  in  1  LSU accepts response
lsu_rsp_rdata  out  DW  extended load data; 0 for stores and errors
lsu_rsp_err  out  1  illegal or misaligned access
ahbm_lsu_req_vld  out  1  bus request valid
ahbm_lsu_req_rdy  in  1  master accepts request
ahbm_lsu_req_wen  out  1  forwarded wen
ahbm_lsu_req_rwtyp  out  3  forwarded rwtyp
ahbm_lsu_req_addr  out  AW  forwarded address, unmodified
ahbm_lsu_req_wdata  out  DW  lane-replicated store data
ahbm_lsu_rsp_vld  in  1  master response valid; exactly one per forwarded request
ahbm_lsu_rsp_rdy  out  1  high only in WAIT_RSP
ahbm_lsu_rsp_rdata  in  DW  raw word-aligned bus word

Behaviour:
- Reset: FIFO empty, count 0, state IDLE.
  - All outputs 0 except lsu_req_rdy=1.
  - Reset mid-transaction drops all entries and any pending response.
- Push when lsu_req_vld && lsu_req_rdy. No bypass: lsu_req_rdy=0 when full, even if a pop occurs that cycle.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Legality is checked at push and stored as an err bit per entry. err=1 when any of:
  - rwtyp in {011, 110, 111};
  - wen=1 with rwtyp 100 or 101;
  - H/HU with addr[0]!=0;
  - W with addr[1:0]!=0.
- Store lane replication:
  - B: wdata[7:0] replicated x4.
  - H: wdata[15:0] replicated x2.
  - W: wdata passed through.
- FSM:
  - IDLE: if FIFO non-empty, go to ERR when head.err, else ISSUE.
  - ISSUE: ahbm_lsu_req_vld=1 with head fields. On ahbm_lsu_req_rdy, pop and go to WAIT_RSP. Fields stay stable while vld=1 and rdy=0.
  - WAIT_RSP: ahbm_lsu_rsp_rdy=1. On ahbm_lsu_rsp_vld, register the extended data into the response register and go to RESP.
  - ERR: pop the head, load rdata=0 and err=1, go to RESP. Takes one cycle.
  - RESP: lsu_rsp_vld=1, outputs held stable. On lsu_rsp_rdy, go to IDLE, or directly to ISSUE/ERR if the FIFO is non-empty.
- Load extraction uses saved addr[1:0] and rwtyp:
  - Byte lane = word >> (8*addr[1:0]); halfword lane = word >> (16*addr[1]).
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Stores respond with rdata=0, err=0.
- Latency (empty queue, zero-wait master and LSU):
  - Push at cycle 0; ahbm_lsu_req_vld at cycle 1.
  - lsu_rsp_vld appears one cycle after ahbm_lsu_rsp_vld.
  - An error response appears at cycle 3.
- Exactly one outstanding bus request. Responses are returned strictly in push order.

Decomposition:
- Shared package lsu_pkg:
  - rwtyp localparams (RW_B, RW_H, RW_W, RW_BU, RW_HU);
  - state enum {IDLE, ISSUE, WAIT_RSP, ERR, RESP};
  - struct lsu_req_t {wen, rwtyp, addr, wdata, err}.
- Sub-module lsu_req_fifo: sync FIFO of lsu_req_t with push/pop/full/empty/count, reset on rst.

Test Plan:
- LW addr 0x100, master returns 0xDEADBEEF → ahbm req addr 0x100, rwtyp 010; lsu_rsp_rdata 0xDEADBEEF, err 0.
- LB addr 0x103, bus word 0x80FF_0000 → rdata 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102, word 0x8001_0000 → 0x00008001.
- SH addr 0x202, wdata 0x1234ABCD → ahbm_lsu_req_wdata 0xABCDABCD; response rdata 0, err 0.
- LW addr 0x101, then SW addr 0x300 → first response err=1 with no bus request for it; SW is then forwarded and responds second.
- Hold ahbm_lsu_req_rdy=0 and push 5 requests with DEPTH=4 → lsu_req_rdy drops after 4 pushes and req fields stay stable. Release → ordered drain, rdy returns.
- Assert rst in WAIT_RSP with 2 entries queued → all outputs return to reset values next edge, count 0; a new request afterwards issues normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU -> AHB request queue.
package lsu_pkg;

  // The queue entry is a packed struct, so its field widths are fixed here;
  // the top-level AW/DW parameters default to these and must match them.
  localparam int LSU_AW = 32;
  localparam int LSU_DW = 32;

  // funct3 access types
  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, ERR, RESP} state_t;

  typedef struct packed {
    logic              wen;
    logic [2:0]        rwtyp;
    logic [LSU_AW-1:0] addr;
    logic [LSU_DW-1:0] wdata;   // already lane-replicated for the bus
    logic              err;     // illegal/misaligned, answered locally
  } lsu_req_t;

  // Reserved encodings, unsigned stores and misaligned H/W are illegal.
  function automatic logic req_illegal(input logic wen, input logic [2:0] rwtyp,
                                       input logic [1:0] off);
    logic bad;
    case (rwtyp)
      RW_B:    bad = 1'b0;
      RW_BU:   bad = wen;
      RW_H:    bad = off[0];
      RW_HU:   bad = wen | off[0];
      RW_W:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replicate store data across every lane it could land on.
  function automatic logic [LSU_DW-1:0] lane_wdata(input logic [2:0] rwtyp,
                                                   input logic [LSU_DW-1:0] wdata);
    logic [LSU_DW-1:0] r;
    case (rwtyp[1:0])
      2'b00:   r = {4{wdata[7:0]}};
      2'b01:   r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of the bus word and extend it.
  function automatic logic [LSU_DW-1:0] load_extract(input logic [2:0] rwtyp,
                                                     input logic [1:0] off,
                                                     input logic [LSU_DW-1:0] word);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [LSU_DW-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (rwtyp)
      RW_B:    r = {{24{b[7]}}, b};
      RW_BU:   r = {24'b0, b};
      RW_H:    r = {{16{h[15]}}, h};
      RW_HU:   r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// Synchronous FIFO of LSU request entries; head is read combinationally.
module lsu_req_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  lsu_req_t                 din,
  output lsu_req_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  lsu_req_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lsu_ahb_req_queue.sv
// LSU request queue: buffers requests, issues them one at a time to the
// AHB master, answers illegal accesses locally and extends load data.
module lsu_ahb_req_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = LSU_AW,
  parameter int DW    = LSU_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_req_vld,
  output logic          lsu_req_rdy,
  input  logic          lsu_req_wen,
  input  logic [2:0]    lsu_req_rwtyp,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic [DW-1:0] lsu_req_wdata,
  output logic          lsu_rsp_vld,
  input  logic          lsu_rsp_rdy,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          lsu_rsp_err,
  output logic          ahbm_lsu_req_vld,
  input  logic          ahbm_lsu_req_rdy,
  output logic          ahbm_lsu_req_wen,
  output logic [2:0]    ahbm_lsu_req_rwtyp,
  output logic [AW-1:0] ahbm_lsu_req_addr,
  output logic [DW-1:0] ahbm_lsu_req_wdata,
  input  logic          ahbm_lsu_rsp_vld,
  output logic          ahbm_lsu_rsp_rdy,
  input  logic [DW-1:0] ahbm_lsu_rsp_rdata
);

  lsu_req_t              in_req, head;
  logic                  in_err, push, pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] unused_level;
  state_t                state, state_nxt;
  logic                  sv_wen;
  logic [2:0]            sv_typ;
  logic [1:0]            sv_off;
  logic [DW-1:0]         rsp_rdata_q;
  logic                  rsp_err_q;

  assign in_err      = req_illegal(lsu_req_wen, lsu_req_rwtyp, lsu_req_addr[1:0]);
  assign lsu_req_rdy = ~fifo_full;
  assign push        = lsu_req_vld & ~fifo_full;
  assign pop         = (state == ISSUE && ahbm_lsu_req_rdy) || (state == ERR);

  // Build the queue entry: legality and lane replication are settled at push.
  always_comb begin
    in_req       = '0;
    in_req.wen   = lsu_req_wen;
    in_req.rwtyp = lsu_req_rwtyp;
    in_req.addr  = lsu_req_addr;
    in_req.wdata = lane_wdata(lsu_req_rwtyp, lsu_req_wdata);
    in_req.err   = in_err;
  end

  lsu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_req),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_level)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state. From IDLE a legal request arriving into an empty queue is
  // issued straight away; an illegal one is found by IDLE on the following
  // cycle, which fixes the local-error path at three cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty)         state_nxt = head.err ? ERR : ISSUE;
        else if (push && !in_err) state_nxt = ISSUE;
      end
      ISSUE:    if (ahbm_lsu_req_rdy) state_nxt = WAIT_RSP;
      WAIT_RSP: if (ahbm_lsu_rsp_vld) state_nxt = RESP;
      ERR:      state_nxt = RESP;
      RESP: begin
        if (lsu_rsp_rdy) state_nxt = fifo_empty ? IDLE : (head.err ? ERR : ISSUE);
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs; bus request fields are zero unless a request is being offered.
  always_comb begin
    ahbm_lsu_req_vld   = (state == ISSUE);
    ahbm_lsu_req_wen   = 1'b0;
    ahbm_lsu_req_rwtyp = '0;
    ahbm_lsu_req_addr  = '0;
    ahbm_lsu_req_wdata = '0;
    if (state == ISSUE) begin
      ahbm_lsu_req_wen   = head.wen;
      ahbm_lsu_req_rwtyp = head.rwtyp;
      ahbm_lsu_req_addr  = head.addr;
      ahbm_lsu_req_wdata = head.wdata;
    end
    ahbm_lsu_rsp_rdy = (state == WAIT_RSP);
    lsu_rsp_vld      = (state == RESP);
    lsu_rsp_rdata    = rsp_rdata_q;
    lsu_rsp_err      = rsp_err_q;
  end

  // Remember what the outstanding bus request needs for extraction, and
  // capture the response (bus data or local error) for the LSU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_wen      <= 1'b0;
      sv_typ      <= '0;
      sv_off      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state == ISSUE && ahbm_lsu_req_rdy) begin
        sv_wen <= head.wen;
        sv_typ <= head.rwtyp;
        sv_off <= head.addr[1:0];
      end
      if (state == WAIT_RSP && ahbm_lsu_rsp_vld) begin
        rsp_rdata_q <= sv_wen ? '0 : load_extract(sv_typ, sv_off, ahbm_lsu_rsp_rdata);
        rsp_err_q   <= 1'b0;
      end else if (state == ERR) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ahb_req_queue.sv
// Self-checking bench for lsu_ahb_req_queue: a queue-based reference model
// predicts every bus request and LSU response; directed tests pin literals.
module tb_lsu_ahb_req_queue;
  import lsu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst;
  logic        lsu_req_vld, lsu_req_rdy, lsu_req_wen;
  logic [2:0]  lsu_req_rwtyp;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic        lsu_rsp_vld, lsu_rsp_rdy, lsu_rsp_err;
  logic [31:0] lsu_rsp_rdata;
  logic        ahbm_lsu_req_vld, ahbm_lsu_req_rdy, ahbm_lsu_req_wen;
  logic [2:0]  ahbm_lsu_req_rwtyp;
  logic [31:0] ahbm_lsu_req_addr, ahbm_lsu_req_wdata;
  logic        ahbm_lsu_rsp_vld, ahbm_lsu_rsp_rdy;
  logic [31:0] ahbm_lsu_rsp_rdata;

  always #5 clk = ~clk;

  lsu_ahb_req_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy), .lsu_req_wen(lsu_req_wen),
    .lsu_req_rwtyp(lsu_req_rwtyp), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .ahbm_lsu_req_vld(ahbm_lsu_req_vld), .ahbm_lsu_req_rdy(ahbm_lsu_req_rdy),
    .ahbm_lsu_req_wen(ahbm_lsu_req_wen), .ahbm_lsu_req_rwtyp(ahbm_lsu_req_rwtyp),
    .ahbm_lsu_req_addr(ahbm_lsu_req_addr), .ahbm_lsu_req_wdata(ahbm_lsu_req_wdata),
    .ahbm_lsu_rsp_vld(ahbm_lsu_rsp_vld), .ahbm_lsu_rsp_rdy(ahbm_lsu_rsp_rdy),
    .ahbm_lsu_rsp_rdata(ahbm_lsu_rsp_rdata)
  );

  typedef struct { bit wen; bit [2:0] typ; bit [31:0] addr, wdata, word; } bus_exp_t;
  typedef struct { bit [31:0] rdata; bit err; } rsp_exp_t;

  bus_exp_t    exp_bus[$];
  rsp_exp_t    exp_rsp[$];
  rsp_exp_t    rsp_log[$];
  bit [31:0]   pend[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, bus_cnt = 0, p_cyc = 0;
  int          t_bus = -1, t_rsp = -1, t_brsp = -1;
  bit          rsp_hold = 1'b0;
  bit [31:0]   cur_word = '0;
  bit [31:0]   last_bus_addr, last_bus_wdata;
  bit [2:0]    last_bus_typ;

  // ---------------- reference model (from the access rules) ----------------
  function automatic bit m_illegal(bit wen, bit [2:0] typ, bit [31:0] addr);
    if (typ == 3 || typ == 6 || typ == 7)       return 1'b1;
    if (wen && (typ == 4 || typ == 5))          return 1'b1;
    if ((typ == 1 || typ == 5) && addr % 2 != 0) return 1'b1;
    if (typ == 2 && addr % 4 != 0)              return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] m_lanes(bit [2:0] typ, bit [31:0] wdata);
    if (typ == 0) return (wdata & 32'hFF) * 32'h0101_0101;
    if (typ == 1) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic bit [31:0] m_load(bit [2:0] typ, bit [31:0] addr, bit [31:0] word);
    bit [31:0] b, h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (typ)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return word;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Track handshakes at the clock edge and advance the model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_bus.delete();
      exp_rsp.delete();
      pend.delete();
    end else begin
      if (ahbm_lsu_rsp_vld && ahbm_lsu_rsp_rdy && pend.size() > 0) pend.pop_front();
      if (lsu_rsp_vld && lsu_rsp_rdy) begin
        rsp_log.push_back('{lsu_rsp_rdata, lsu_rsp_err});
        if (exp_rsp.size() > 0) exp_rsp.pop_front();
      end
      if (ahbm_lsu_req_vld && ahbm_lsu_req_rdy) begin
        bus_cnt <= bus_cnt + 1;
        last_bus_addr  <= ahbm_lsu_req_addr;
        last_bus_wdata <= ahbm_lsu_req_wdata;
        last_bus_typ   <= ahbm_lsu_req_rwtyp;
        if (exp_bus.size() > 0) begin
          pend.push_back(exp_bus[0].word);
          exp_bus.pop_front();
        end
      end
      if (lsu_req_vld && lsu_req_rdy) begin
        if (m_illegal(lsu_req_wen, lsu_req_rwtyp, lsu_req_addr)) begin
          exp_rsp.push_back('{32'h0, 1'b1});
        end else begin
          exp_bus.push_back('{lsu_req_wen, lsu_req_rwtyp, lsu_req_addr,
                              m_lanes(lsu_req_rwtyp, lsu_req_wdata), cur_word});
          exp_rsp.push_back('{lsu_req_wen ? 32'h0 : m_load(lsu_req_rwtyp, lsu_req_addr, cur_word), 1'b0});
        end
      end
    end
  end

  // Bus master model plus per-cycle compare, away from the rising edge.
  always @(negedge clk) begin
    ahbm_lsu_rsp_vld   = !rsp_hold && pend.size() > 0;
    ahbm_lsu_rsp_rdata = (pend.size() > 0) ? pend[0] : 32'h0;
    if (!rst) begin
      if (ahbm_lsu_rsp_vld && t_brsp < 0) t_brsp = cyc;
      if (ahbm_lsu_req_vld) begin
        if (t_bus < 0) t_bus = cyc;
        if (exp_bus.size() == 0) fail("bus_req_unexpected");
        else begin
          check("bus_wen",   ahbm_lsu_req_wen,   exp_bus[0].wen);
          check("bus_rwtyp", ahbm_lsu_req_rwtyp, exp_bus[0].typ);
          check("bus_addr",  ahbm_lsu_req_addr,  exp_bus[0].addr);
          check("bus_wdata", ahbm_lsu_req_wdata, exp_bus[0].wdata);
        end
      end
      if (lsu_rsp_vld) begin
        if (t_rsp < 0) t_rsp = cyc;
        if (exp_rsp.size() == 0) fail("rsp_unexpected");
        else begin
          check("rsp_rdata", lsu_rsp_rdata, exp_rsp[0].rdata);
          check("rsp_err",   lsu_rsp_err,   exp_rsp[0].err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input bit wen, input bit [2:0] typ, input bit [31:0] addr,
                      input bit [31:0] wdata, input bit [31:0] word);
    int n = 0;
    t_bus = -1; t_rsp = -1; t_brsp = -1;
    lsu_req_vld = 1'b1; lsu_req_wen = wen; lsu_req_rwtyp = typ;
    lsu_req_addr = addr; lsu_req_wdata = wdata; cur_word = word;
    while (!lsu_req_rdy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail("push_timeout");
    p_cyc = cyc;
    @(negedge clk);
    lsu_req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_bus.size() > 0 || exp_rsp.size() > 0 || pend.size() > 0 || lsu_rsp_vld) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) fail("drain_timeout");
  endtask

  initial begin
    int b0, n0;
    rst = 1'b1; lsu_req_vld = 0; lsu_req_wen = 0; lsu_req_rwtyp = 0;
    lsu_req_addr = 0; lsu_req_wdata = 0; lsu_rsp_rdy = 1; ahbm_lsu_req_rdy = 1;
    repeat (2) @(negedge clk);
    check("rst_req_rdy",  lsu_req_rdy, 1);
    check("rst_bus_vld",  ahbm_lsu_req_vld, 0);
    check("rst_rsp_vld",  lsu_rsp_vld, 0);
    check("rst_bus_rrdy", ahbm_lsu_rsp_rdy, 0);
    check("rst_rsp_data", lsu_rsp_rdata, 0);
    check("rst_bus_addr", ahbm_lsu_req_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word load, with latency pins.
    push(0, RW_W, 32'h100, 0, 32'hDEAD_BEEF);
    wait_idle();
    check("lw_bus_lat", t_bus - p_cyc, 1);
    check("lw_rsp_lat", t_rsp - t_brsp, 1);
    check("lw_addr",  last_bus_addr, 32'h100);
    check("lw_typ",   last_bus_typ, 3'b010);
    check("lw_rdata", rsp_log[$].rdata, 32'hDEAD_BEEF);
    check("lw_err",   rsp_log[$].err, 0);

    // Byte load held off by the LSU for a few cycles.
    lsu_rsp_rdy = 1'b0;
    push(0, RW_B, 32'h103, 0, 32'h80FF_0000);
    for (int i = 0; i < 20 && !lsu_rsp_vld; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    lsu_rsp_rdy = 1'b1;
    wait_idle();
    check("lb_rdata", rsp_log[$].rdata, 32'hFFFF_FF80);
    push(0, RW_BU, 32'h103, 0, 32'h80FF_0000);
    wait_idle();
    check("lbu_rdata", rsp_log[$].rdata, 32'h0000_0080);
    push(0, RW_HU, 32'h102, 0, 32'h8001_0000);
    wait_idle();
    check("lhu_rdata", rsp_log[$].rdata, 32'h0000_8001);
    push(0, RW_H, 32'h002, 0, 32'hF00D_1234);
    wait_idle();
    check("lh_rdata", rsp_log[$].rdata, 32'hFFFF_F00D);

    // Stores: lane replication, zero response.
    push(1, RW_H, 32'h202, 32'h1234_ABCD, 32'h5555_5555);
    wait_idle();
    check("sh_wdata", last_bus_wdata, 32'hABCD_ABCD);
    check("sh_rdata", rsp_log[$].rdata, 0);
    check("sh_err",   rsp_log[$].err, 0);
    push(1, RW_B, 32'h005, 32'h0000_00AB, 32'h0);
    wait_idle();
    check("sb_wdata", last_bus_wdata, 32'hABAB_ABAB);

    // Local error alone: fixed latency, no bus traffic.
    b0 = bus_cnt;
    push(0, RW_W, 32'h101, 0, 32'h0);
    wait_idle();
    check("err_lat",   t_rsp - p_cyc, 3);
    check("err_flag",  rsp_log[$].err, 1);
    check("err_rdata", rsp_log[$].rdata, 0);
    check("err_nobus", bus_cnt, b0);

    // Error followed by a store: in-order responses, only the store on the bus.
    b0 = bus_cnt; n0 = rsp_log.size();
    push(0, RW_W, 32'h101, 0, 32'h0);
    push(1, RW_W, 32'h300, 32'h0BAD_F00D, 32'h0);
    wait_idle();
    check("mix_bus_cnt", bus_cnt, b0 + 1);
    check("mix_addr",    last_bus_addr, 32'h300);
    check("mix_err0",    rsp_log[n0].err, 1);
    check("mix_err1",    rsp_log[n0 + 1].err, 0);

    // Other illegal forms.
    push(1, RW_BU, 32'h10, 0, 0); wait_idle(); check("sbu_err", rsp_log[$].err, 1);
    push(0, 3'b011, 32'h10, 0, 0); wait_idle(); check("typ3_err", rsp_log[$].err, 1);
    push(0, RW_H, 32'h11, 0, 0);  wait_idle(); check("lh_mis_err", rsp_log[$].err, 1);

    // Stalled master: queue fills, request stays stable, then ordered drain.
    b0 = bus_cnt; n0 = rsp_log.size();
    ahbm_lsu_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(0, RW_W, 32'h400 + 4*i, 0, 32'h1000 + i);
    check("full_rdy", lsu_req_rdy, 0);
    fork
      push(0, RW_W, 32'h410, 0, 32'h1004);
      begin
        repeat (3) @(negedge clk);
        check("stall_rdy",  lsu_req_rdy, 0);
        check("stall_addr", ahbm_lsu_req_addr, 32'h400);
        ahbm_lsu_req_rdy = 1'b1;
      end
    join
    wait_idle();
    check("drain_cnt", bus_cnt, b0 + 5);
    check("drain_rdy", lsu_req_rdy, 1);
    for (int i = 0; i < 5; i++) check("drain_order", rsp_log[n0 + i].rdata, 32'h1000 + i);

    // Reset while waiting on the bus with two entries queued.
    rsp_hold = 1'b1;
    push(0, RW_W, 32'h500, 0, 32'h1);
    push(0, RW_W, 32'h504, 0, 32'h2);
    push(0, RW_W, 32'h508, 0, 32'h3);
    check("pre_rst_wait", ahbm_lsu_rsp_rdy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy",  lsu_req_rdy, 1);
    check("mid_rst_bvld", ahbm_lsu_req_vld, 0);
    check("mid_rst_rrdy", ahbm_lsu_rsp_rdy, 0);
    check("mid_rst_rvld", lsu_rsp_vld, 0);
    rsp_hold = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n0 = rsp_log.size();
    push(0, RW_W, 32'h600, 0, 32'hCAFE_F00D);
    wait_idle();
    check("post_rst_lat",   t_bus - p_cyc, 1);
    check("post_rst_count", rsp_log.size(), n0 + 1);
    check("post_rst_rdata", rsp_log[$].rdata, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
